// File: rtl/umi_rr_merge.sv
// N-input round-robin merge of UMI streams onto a single registered UMI output.
// A rotating priority pointer gives fairness; the output register isolates downstream backpressure.
module umi_rr_merge #(
    parameter int N  = 2,
    parameter int DW = 256,
    parameter int AW = 64,
    parameter int CW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic          r_out_valid;
    logic [CW-1:0] r_cmd;
    logic [AW-1:0] r_dstaddr;
    logic [AW-1:0] r_srcaddr;
    logic [DW-1:0] r_data;

    logic [PW-1:0] w_winner;
    logic [PW-1:0] w_ptr_next;
    logic          w_any;
    logic          w_load;
    logic          w_accept;

    // Handshake: a beat moves on any port when valid && ready are both high at the
    // rising clk edge; inputs hold their fields until accepted, valid never waits on ready.
    assign w_load   = !r_out_valid || umi_out_ready;
    assign w_accept = !rst && w_load && w_any;

    // Scan from ptr upward with wrap; iterating downward lets the nearest valid port win.
    always_comb begin
        logic [PW-1:0] cand;
        cand     = '0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(r_ptr) + k) % N);
            if (umi_in_valid[cand]) begin
                w_any    = 1'b1;
                w_winner = cand;
            end
        end
    end

    always_comb begin
        umi_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_accept && (w_winner == PW'(i))) begin
                umi_in_ready[i] = 1'b1;
            end
        end
    end

    assign w_ptr_next = (int'(w_winner) == N - 1) ? '0 : w_winner + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_cmd       <= '0;
            r_dstaddr   <= '0;
            r_srcaddr   <= '0;
            r_data      <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_any;
                if (w_any) begin
                    r_cmd     <= umi_in_cmd[w_winner*CW +: CW];
                    r_dstaddr <= umi_in_dstaddr[w_winner*AW +: AW];
                    r_srcaddr <= umi_in_srcaddr[w_winner*AW +: AW];
                    r_data    <= umi_in_data[w_winner*DW +: DW];
                end
            end
            if (w_accept) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign umi_out_valid   = r_out_valid;
    assign umi_out_cmd     = r_cmd;
    assign umi_out_dstaddr = r_dstaddr;
    assign umi_out_srcaddr = r_srcaddr;
    assign umi_out_data    = r_data;

endmodule

// File: doc/umi_rr_merge.md
Name: umi_rr_merge

Overview:
- N-input round-robin arbiter that merges several UMI streams onto one UMI output. It is the complement of umi_splitter.
- Typical use: recombining the request and response streams into a single link toward a queue bridge such as umi_to_queue_sim.
- Fairness comes from a rotating priority pointer.
- A single registered output stage decouples downstream backpressure from the arbitration logic.

Parameters:
- N, 2, number of input UMI ports (≥2).
- DW, 256, UMI data width.
- AW, 64, UMI address width.
- CW, 32, UMI command width.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- umi_in_valid  input  N  per-port valid.
- umi_in_cmd  input  N*CW  flattened commands; port i occupies [i*CW +: CW].
- umi_in_dstaddr  input  N*AW  flattened destination addresses.
- umi_in_srcaddr  input  N*AW  flattened source addresses.
- umi_in_data  input  N*DW  flattened data.
- umi_in_ready  output  N  per-port ready.
- umi_out_valid  output  1  output valid (registered).
- umi_out_cmd  output  CW  registered command.
- umi_out_dstaddr  output  AW  registered destination address.
- umi_out_srcaddr  output  AW  registered source address.
- umi_out_data  output  DW  registered data.
- umi_out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - umi_out_valid=0.
  - umi_out_cmd/dstaddr/srcaddr/data=0.
  - Priority pointer ptr=0.
  - umi_in_ready is 0 while rst=1.
  - Reset mid-transfer discards the held output beat; there is no partial state.
- Transfer rule: a beat moves on any port when valid&&ready are both high at the clk edge.
- Output register:
  - load = !umi_out_valid || umi_out_ready.
  - When load and a grant exists, the register captures the winner's fields and umi_out_valid<=1.
  - When load and no grant exists, umi_out_valid<=0.
  - When load=0, all output fields hold stable until accepted.
- Arbitration (combinational):
  - Scan ports ptr, ptr+1, … N-1, 0, … ptr-1.
  - The first port with umi_in_valid=1 wins.
  - umi_in_ready[i] = load && (i==winner). At most one ready bit is high per cycle; a non-valid port never sees ready.
- Pointer update: on an accepted input beat from winner g, ptr <= (g+1) mod N. Otherwise ptr holds.
  - Wrap: g=N-1 gives ptr=0.
  - Any port continuously valid is served within N accepted beats.
- Latency:
  - Input accept to umi_out_valid is 1 cycle.
  - Full throughput (1 beat/cycle) while umi_out_ready=1.
  - Simultaneous drain and refill in the same cycle is allowed (load via umi_out_ready).
- Backpressure:
  - umi_in_ready depends combinationally on umi_out_ready and umi_in_valid.
  - Senders must not make valid depend on ready.
  - A valid input must hold its fields until accepted.
- The payload is passed unmodified. There is no inspection of cmd and no reordering within a port.
- Empty boundary: all inputs idle and the output drained gives umi_out_valid=0. The first new beat appears the next cycle.
- Full boundary: umi_out_valid=1 with umi_out_ready=0 gives umi_in_ready=0 on all ports. The pointer and register are frozen.

Test Plan:
- Reset: hold rst 3 cycles with all inputs valid -> umi_out_valid=0, umi_in_ready=00, outputs 0. After release, port0 is granted first (ptr=0).
- Single port: only port1 valid, with cmd=0x0000_0013, dstaddr=0x1000, data=0xA5 repeating, out_ready=1 -> identical beat on out 1 cycle later. A 10-beat burst yields 10 consecutive out cycles.
- Contention: N=2, both valid continuously, out_ready=1 -> output source alternates 0,1,0,1 for 8 beats, each port accepted exactly 4 times.
- Backpressure: output held 5 cycles with out_ready=0 -> out fields stable, umi_in_ready=00, ptr unchanged. On release, queued beats drain with no loss and no duplication.
- Wrap/fairness N=4: ports 1 and 3 valid, ptr=2 -> order 3,1,3,1. Port 0 becomes valid after port 3 is served -> order continues 0,1,3.
- Mid-operation reset: rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, ptr=0. A queue-driven comparison against a Python model (in.q sources, out.q sink) shows no stray beats.
